// File: rtl/apb_slave_regbank.sv
// APB slave register bank: ID, control, scratch, free-running counter, W1C status
// and access counters, with protocol checking and a registered error interrupt.
module apb_slave_regbank #(
  parameter int unsigned SLV_INDEX = 0,
  parameter logic [31:0] ID_CODE   = 32'hA2B0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        err_irq
);

  localparam logic [1:0]  SEL_BIT = SLV_INDEX[1:0];
  localparam logic [31:0] ID_VAL  = ID_CODE | 32'(SLV_INDEX);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_rdata;
  logic        r_cnt_en;
  logic [2:0]  r_irq_mask;
  logic [31:0] r_scratch0;
  logic [31:0] r_scratch1;
  logic [31:0] r_count;
  logic [2:0]  r_status;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;
  logic        r_err_irq;

  logic        w_sel;
  logic        w_setup;
  logic        w_access;
  logic        w_proto_err;
  logic        w_wr_acc;
  logic        w_rd_acc;
  logic [3:0]  w_idx;
  logic        w_unmapped;
  logic        w_ro_off;
  logic        w_ctrl_wr;
  logic [2:0]  w_w1c;
  logic [2:0]  w_status_set;
  logic [31:0] w_rd_mux;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_nxt = w_setup ? ST_SETUP : ST_IDLE;
      ST_SETUP:  w_state_nxt = w_access ? ST_ACCESS : (w_setup ? ST_SETUP : ST_IDLE);
      ST_ACCESS: w_state_nxt = w_setup ? ST_SETUP : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // An access is only honoured if address and direction still match the setup phase.
  always_comb begin
    w_sel       = |(Pselx & (3'b001 << SEL_BIT));
    w_setup     = w_sel & ~Penable;
    w_access    = (r_state == ST_SETUP) & w_sel & Penable &
                  (Paddr == r_addr) & (Pwrite == r_write);
    w_proto_err = ((r_state == ST_IDLE) & w_sel & Penable) |
                  ((r_state == ST_SETUP) & ~w_access);
    w_wr_acc    = w_access & r_write;
    w_rd_acc    = w_access & ~r_write;
    Prdata      = (w_rd_acc & ~rst) ? r_rdata : 32'd0;
  end

  always_comb begin
    w_idx        = r_addr[5:2];
    w_unmapped   = w_idx[3];
    w_ro_off     = ~w_idx[3] & ((w_idx[2:0] == 3'd0) | (w_idx[2:0] == 3'd4) |
                                (w_idx[2:0] == 3'd6) | (w_idx[2:0] == 3'd7));
    w_ctrl_wr    = w_wr_acc & (w_idx == 4'd1);
    w_w1c        = (w_wr_acc & (w_idx == 4'd5)) ? Pwdata[2:0] : 3'b000;
    w_status_set = {w_access & w_unmapped, w_proto_err, w_wr_acc & w_ro_off};
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (Paddr[5:2])
      4'd0:    w_rd_mux = ID_VAL;
      4'd1:    w_rd_mux = {27'd0, r_irq_mask, 1'b0, r_cnt_en};
      4'd2:    w_rd_mux = r_scratch0;
      4'd3:    w_rd_mux = r_scratch1;
      4'd4:    w_rd_mux = r_count;
      4'd5:    w_rd_mux = {29'd0, r_status};
      4'd6:    w_rd_mux = {16'd0, r_wr_cnt};
      4'd7:    w_rd_mux = {16'd0, r_rd_cnt};
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= 32'd0;
      r_write    <= 1'b0;
      r_rdata    <= 32'd0;
      r_cnt_en   <= 1'b0;
      r_irq_mask <= 3'd0;
      r_scratch0 <= 32'd0;
      r_scratch1 <= 32'd0;
      r_count    <= 32'd0;
      r_status   <= 3'd0;
      r_wr_cnt   <= 16'd0;
      r_rd_cnt   <= 16'd0;
      r_err_irq  <= 1'b0;
    end else begin
      if (w_setup) begin
        r_addr  <= Paddr;
        r_write <= Pwrite;
        r_rdata <= w_rd_mux;
      end
      if (w_ctrl_wr) begin
        r_cnt_en   <= Pwdata[0];
        r_irq_mask <= Pwdata[4:2];
      end
      if (w_wr_acc && (w_idx == 4'd2)) r_scratch0 <= Pwdata;
      if (w_wr_acc && (w_idx == 4'd3)) r_scratch1 <= Pwdata;
      if (w_ctrl_wr && Pwdata[1]) r_count <= 32'd0;
      else if (r_cnt_en)          r_count <= r_count + 32'd1;
      r_status <= (r_status & ~w_w1c) | w_status_set;
      if (w_wr_acc) r_wr_cnt <= sat_inc16(r_wr_cnt);
      if (w_rd_acc) r_rd_cnt <= sat_inc16(r_rd_cnt);
      r_err_irq <= |(r_status & r_irq_mask);
    end
  end

  assign err_irq = r_err_irq;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: vector table of APB transfers plus
// hand-written sequences for counter timing, interrupts, protocol errors and reset.
module tb_apb_slave_regbank;

  localparam int unsigned SLV   = 1;
  localparam logic [31:0] ID    = 32'hA2B0_0001;
  localparam logic [2:0]  MY    = 3'b010;
  localparam logic [2:0]  OTHER = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        err_irq;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[26];

  apb_slave_regbank #(.SLV_INDEX(SLV), .ID_CODE(32'hA2B0_0000)) dut (
    .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'd0; Pwdata = 32'd0;
    end
    #1;
  endtask

  task automatic cyc(input logic [2:0] sel, input logic en, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Pselx = sel; Penable = en; Pwrite = wr; Paddr = a; Pwdata = d;
    #1;
  endtask

  // Setup then access, no trailing idle; Prdata checked in both phases.
  task automatic xfer(input string name, input logic [2:0] sel, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    cyc(sel, 1'b0, wr, a, d);
    chk({name, "_setup"}, Prdata, 32'd0);
    cyc(sel, 1'b1, wr, a, d);
    chk(name, Prdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 32'h08, 32'hDEAD_BEEF, 32'h0);
    tbl[1]  = mk(0, 32'h08, 32'h0,         32'hDEAD_BEEF);
    tbl[2]  = mk(0, 32'h1C, 32'h0,         32'h1);
    tbl[3]  = mk(0, 32'h18, 32'h0,         32'h1);
    tbl[4]  = mk(0, 32'h00, 32'h0,         ID);
    tbl[5]  = mk(1, 32'h0C, 32'h1234_5678, 32'h0);
    tbl[6]  = mk(0, 32'h0C, 32'h0,         32'h1234_5678);
    tbl[7]  = mk(1, 32'h04, 32'hFFFF_FFFE, 32'h0);
    tbl[8]  = mk(0, 32'h04, 32'h0,         32'h1C);
    tbl[9]  = mk(1, 32'h04, 32'h0,         32'h0);
    tbl[10] = mk(0, 32'h04, 32'h0,         32'h0);
    tbl[11] = mk(0, 32'h10, 32'h0,         32'h0);
    tbl[12] = mk(0, 32'h14, 32'h0,         32'h0);
    tbl[13] = mk(0, 32'h20, 32'h0,         32'h0);
    tbl[14] = mk(0, 32'h14, 32'h0,         32'h4);
    tbl[15] = mk(1, 32'h3C, 32'h55,        32'h0);
    tbl[16] = mk(1, 32'h14, 32'h4,         32'h0);
    tbl[17] = mk(0, 32'h14, 32'h0,         32'h0);
    tbl[18] = mk(1, 32'h00, 32'hFFFF_FFFF, 32'h0);
    tbl[19] = mk(0, 32'h14, 32'h0,         32'h1);
    tbl[20] = mk(0, 32'h00, 32'h0,         ID);
    tbl[21] = mk(1, 32'h14, 32'h1,         32'h0);
    tbl[22] = mk(0, 32'h14, 32'h0,         32'h0);
    tbl[23] = mk(0, 32'h18, 32'h0,         32'h8);
    tbl[24] = mk(0, 32'h1C, 32'h0,         32'h10);
    tbl[25] = mk(0, 32'h08, 32'h0,         32'hDEAD_BEEF);

    rst = 1'b1;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'd0; Pwdata = 32'd0;
    idle(3);
    chk("reset_prdata", Prdata, 32'd0);
    chk("reset_irq", {31'd0, err_irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Vector table, applied back to back.
    for (int i = 0; i < 26; i++)
      xfer($sformatf("vec%0d", i), MY, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Counter: enable, 10 idle cycles, read value sampled at setup edge.
    xfer("cnt_en_wr", MY, 1'b1, 32'h04, 32'h1, 32'h0);
    idle(10);
    xfer("cnt_read10", MY, 1'b0, 32'h10, 32'h0, 32'd10);
    xfer("cnt_clr_wr", MY, 1'b1, 32'h04, 32'h3, 32'h0);
    xfer("cnt_after_clr", MY, 1'b0, 32'h10, 32'h0, 32'd0);
    idle(3);
    xfer("cnt_resume", MY, 1'b0, 32'h10, 32'h0, 32'd5);

    // RO write error and interrupt timing.
    xfer("ctrl_stop_mask0", MY, 1'b1, 32'h04, 32'h6, 32'h0);
    xfer("ro_count_wr", MY, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0);
    idle(1);
    chk("irq_not_yet", {31'd0, err_irq}, 32'd0);
    idle(1);
    chk("irq_set", {31'd0, err_irq}, 32'd1);
    xfer("count_unchanged", MY, 1'b0, 32'h10, 32'h0, 32'd0);
    xfer("status_ro_err", MY, 1'b0, 32'h14, 32'h0, 32'h1);
    xfer("ctrl_read", MY, 1'b0, 32'h04, 32'h0, 32'h4);
    xfer("status_w1c", MY, 1'b1, 32'h14, 32'h1, 32'h0);
    idle(1);
    chk("irq_still_set", {31'd0, err_irq}, 32'd1);
    idle(1);
    chk("irq_cleared", {31'd0, err_irq}, 32'd0);
    xfer("status_clear_rd", MY, 1'b0, 32'h14, 32'h0, 32'h0);

    // Protocol errors: access without setup, address changed, write address changed.
    idle(1);
    cyc(MY, 1'b1, 1'b0, 32'h08, 32'h0);
    chk("noset_prdata", Prdata, 32'd0);
    idle(1);
    xfer("proto_status1", MY, 1'b0, 32'h14, 32'h0, 32'h2);
    xfer("proto_clr", MY, 1'b1, 32'h14, 32'h2, 32'h0);
    xfer("proto_clr_rd", MY, 1'b0, 32'h14, 32'h0, 32'h0);
    cyc(MY, 1'b0, 1'b0, 32'h08, 32'h0);
    cyc(MY, 1'b1, 1'b0, 32'h0C, 32'h0);
    chk("addr_chg_prdata", Prdata, 32'd0);
    idle(1);
    cyc(MY, 1'b0, 1'b1, 32'h08, 32'h1111_1111);
    cyc(MY, 1'b1, 1'b1, 32'h0C, 32'h1111_1111);
    idle(1);
    xfer("proto_s0_kept", MY, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF);
    xfer("proto_s1_kept", MY, 1'b0, 32'h0C, 32'h0, 32'h1234_5678);
    xfer("proto_status2", MY, 1'b0, 32'h14, 32'h0, 32'h2);
    xfer("wr_cnt_total", MY, 1'b0, 32'h18, 32'h0, 32'd14);

    // Other slave selected: nothing changes, Prdata stays 0.
    xfer("mask_proto", MY, 1'b1, 32'h04, 32'h8, 32'h0);
    idle(2);
    chk("irq_proto", {31'd0, err_irq}, 32'd1);
    xfer("other_wr", OTHER, 1'b1, 32'h08, 32'h0, 32'h0);
    xfer("other_rd", OTHER, 1'b0, 32'h08, 32'h0, 32'h0);
    xfer("other_s0_kept", MY, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF);
    xfer("other_status", MY, 1'b0, 32'h14, 32'h0, 32'h2);

    // Reset during read access and during write access.
    cyc(MY, 1'b0, 1'b0, 32'h08, 32'h0);
    @(negedge clk);
    Penable = 1'b1; rst = 1'b1;
    #1;
    chk("rst_rd_prdata", Prdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("rst_after_prdata", Prdata, 32'd0);
    chk("rst_after_irq", {31'd0, err_irq}, 32'd0);
    cyc(MY, 1'b0, 1'b1, 32'h0C, 32'hAAAA_AAAA);
    @(negedge clk);
    Penable = 1'b1; rst = 1'b1;
    #1;
    chk("rst_wr_prdata", Prdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    xfer("rst_s1", MY, 1'b0, 32'h0C, 32'h0, 32'h0);
    xfer("rst_s0", MY, 1'b0, 32'h08, 32'h0, 32'h0);
    xfer("rst_wr_cnt", MY, 1'b0, 32'h18, 32'h0, 32'h0);
    xfer("rst_id", MY, 1'b0, 32'h00, 32'h0, ID);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 SHALL have parameter SLV_INDEX, default 0: Pselx bit (0..2) that selects this slave.
REQ-002 SHALL have parameter ID_CODE, default 32'hA2B0_0000: value returned at offset 0x00, OR'd with SLV_INDEX.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Pselx  input  3  APB select from bridge; only bit SLV_INDEX is used.
REQ-006 Penable  input  1  APB access-phase strobe.
REQ-007 Pwrite  input  1  1 = write, 0 = read.
REQ-008 Paddr  input  32  byte address; only Paddr[5:2] decoded.
REQ-009 Pwdata  input  32  write data.
REQ-010 Prdata  output  32  read data; 0 whenever not in a read access cycle, so three slaves can be OR-combined.
REQ-011 err_irq  output  1  registered level interrupt.

Function
REQ-012 Cycle types, sel = Pselx[SLV_INDEX]:
- setup cycle = sel & !Penable
- access cycle = sel & Penable in the cycle directly after a setup cycle
REQ-013 FSM states and transitions:
- IDLE -> SETUP on setup cycle.
- SETUP -> ACCESS on sel & Penable with Paddr/Pwrite equal to values captured in setup; otherwise proto error and -> IDLE (or SETUP if current cycle is itself a setup cycle).
- ACCESS -> SETUP on setup cycle (back-to-back), else -> IDLE.
- sel & Penable while in IDLE: proto error, state stays IDLE, no access.
REQ-014 Zero wait states; no Pready/Pslverr.
REQ-015 Read path:
- Prdata registered at the edge ending the setup cycle.
- Driven during the access cycle only; 0 all other cycles.
REQ-016 Write commit at the edge ending the access cycle; new value readable from the next setup onward.
REQ-017 Register map (offset, access, reset):
- 0x00 ID RO = ID_CODE | SLV_INDEX
- 0x04 CTRL RW, reset 0: [0] cnt_en, [1] cnt_clr (self-clearing, always reads 0), [4:2] irq_mask for STATUS[2:0], others read 0
- 0x08 SCRATCH0 RW, reset 0
- 0x0C SCRATCH1 RW, reset 0
- 0x10 COUNT RO, reset 0
- 0x14 STATUS W1C, reset 0: [0] ro_wr_err, [1] proto_err, [2] unmapped_err
- 0x18 WR_CNT RO, reset 0: completed writes, 16-bit saturating at 16'hFFFF, zero-extended
- 0x1C RD_CNT RO, reset 0: completed reads, 16-bit saturating, zero-extended
REQ-018 Offsets 0x20-0x3C are unmapped: read returns 0, write ignored, STATUS[2] set on each access; access still counted in WR_CNT/RD_CNT.
REQ-019 Writes to RO offsets (0x00, 0x10, 0x18, 0x1C) SHALL be ignored and SHALL set STATUS[0].
REQ-020 COUNT increments by 1 each cycle while cnt_en = 1, wrapping 32'hFFFF_FFFF -> 0.
REQ-021 A CTRL write with bit1 = 1 SHALL zero COUNT at that commit edge; clear wins over increment.
REQ-022 STATUS set event coincident with a W1C write to the same bit: set wins.
REQ-023 err_irq is registered: |(STATUS[2:0] & CTRL[4:2]), updated one cycle after STATUS/CTRL change.
REQ-024 Prdata for a read of COUNT SHALL return the value sampled at the setup-cycle edge.

Reset
REQ-025 With rst = 1 at an edge: all registers, counters, STATUS, FSM (-> IDLE), Prdata and err_irq SHALL be 0.
REQ-026 Reset asserted mid-access SHALL abort it: no commit, no counter update, Prdata 0 next cycle.

Verification
REQ-027 Write SCRATCH0 = 32'hDEAD_BEEF (setup+access), then read 0x08 -> Prdata = 32'hDEAD_BEEF in access cycle only, 0 in setup; WR_CNT = 1, RD_CNT = 1.
REQ-028 Back-to-back write 0x0C = 32'h1234_5678 then read 0x0C with no idle cycle -> read returns 32'h1234_5678; FSM ACCESS -> SETUP -> ACCESS.
REQ-029 Write CTRL = 32'h1, idle 10 cycles, read COUNT -> nonzero, equal to count at read setup edge; write CTRL = 32'h3 -> COUNT = 0 next cycle, then counting resumes.
REQ-030 Write 0x10 = 32'hFFFF_FFFF -> COUNT unchanged, STATUS = 3'b001; with CTRL[2] = 1, err_irq = 1 one cycle later; write STATUS = 1 -> STATUS = 0, err_irq = 0.
REQ-031 Penable = 1 without prior setup, and Paddr changed between setup and access -> STATUS[1] = 1, no register modified, Prdata stays 0.
REQ-032 Pselx selecting a different slave with a valid setup/access -> no state change, Prdata = 0 throughout; rst pulse during an access -> all outputs 0 and no commit.
